// File: rtl/slant_arb_pkg.sv
// slant_arb_pkg
//   Shared types for the slant Y/C memory read arbiter.
//   arb_state_t : arbitration FSM states
//   owner_tag_t : {valid,is_tx} tag carried alongside an issued read
//   STAT_W      : width of the optional grant statistics counters
//   sat_inc     : saturating increment used by the statistics counters
package slant_arb_pkg;

  typedef enum logic {
    ARB_HDMI     = 1'b0,
    ARB_TX_FORCE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic is_tx;
  } owner_tag_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic              en);
    if (en && (v != {STAT_W{1'b1}})) begin
      return v + 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/slant_arb_retpipe.sv
// slant_arb_retpipe
//   RD_LAT-deep shift register for read owner tags, so the tag emerges at
//   the tail in the same cycle the memory returns the matching word.
//   Ports:
//     i_clk   clock
//     i_rst_n async active-low clear (drops every in-flight tag)
//     i_tag   tag of the read issued this cycle
//     o_tag   tag of the read whose data is on the memory bus this cycle
module slant_arb_retpipe
  import slant_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  owner_tag_t i_tag,
  output owner_tag_t o_tag
);

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      owner_tag_t r_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) r_q <= '0;
          else          r_q <= i_tag;
        end
      end else begin : g_body
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) r_q <= '0;
          else          r_q <= g_stage[gi-1].r_q;
        end
      end
    end
  endgenerate

  assign o_tag = g_stage[RD_LAT-1].r_q;

endmodule

// File: rtl/slant_rd_arbiter.sv
// slant_rd_arbiter
//   Shares the single read port of the 4-bank slant Y/C memory between the
//   HDMI scan-out reader (priority) and the radio transmit reader, which is
//   guaranteed a slot after STARVE_MAX consecutive lost cycles. Each issued
//   read is tagged and the returned word is routed to its requester.
//   Ports:
//     Cclk, rstn                       clock, async active-low reset
//     mem_block                        write side owns the port; no grant
//     hdmi_req/addr -> hdmi_gnt        HDMI request / accept
//     hdmi_rvalid, hdmi_rdata          HDMI return
//     tx_req/addr   -> tx_gnt          transmit request / accept
//     tx_rvalid, tx_rdata              transmit return
//     mem_re, mem_addr, mem_rdata      memory read port
//   Optional build macro ARB_STATS_EN adds stat_clr, stat_hdmi, stat_tx,
//   stat_force (saturating grant counters).
module slant_rd_arbiter
  import slant_arb_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 20,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              Cclk,
  input  logic              rstn,
  input  logic              mem_block,
  input  logic              hdmi_req,
  input  logic [ADDR_W-1:0] hdmi_addr,
  output logic              hdmi_gnt,
  output logic              hdmi_rvalid,
  output logic [DATA_W-1:0] hdmi_rdata,
  input  logic              tx_req,
  input  logic [ADDR_W-1:0] tx_addr,
  output logic              tx_gnt,
  output logic              tx_rvalid,
  output logic [DATA_W-1:0] tx_rdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_hdmi,
  output logic [STAT_W-1:0] stat_tx,
  output logic [STAT_W-1:0] stat_force
`endif
);

  localparam logic [7:0] LP_MAX = 8'(STARVE_MAX);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [7:0]        r_starve_cnt;
  logic [7:0]        w_starve_next;
  logic              w_hdmi_gnt;
  logic              w_tx_gnt;
  owner_tag_t        w_tag;
  owner_tag_t        w_tail;
  logic [DATA_W-1:0] r_hdmi_hold;
  logic [DATA_W-1:0] r_tx_hold;

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ARB_HDMI;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  always_comb begin
    w_hdmi_gnt    = 1'b0;
    w_tx_gnt      = 1'b0;
    w_state_next  = r_state;
    w_starve_next = r_starve_cnt;
    case (r_state)
      ARB_HDMI: begin
        if (!mem_block) begin
          if (hdmi_req)    w_hdmi_gnt = 1'b1;
          else if (tx_req) w_tx_gnt   = 1'b1;
          if (w_tx_gnt)
            w_starve_next = '0;
          else if (tx_req && (r_starve_cnt != LP_MAX))
            w_starve_next = r_starve_cnt + 8'd1;
        end
        // Switch on the cycle the count reaches the limit so the forced slot
        // follows exactly STARVE_MAX lost cycles.
        if (w_starve_next == LP_MAX) w_state_next = ARB_TX_FORCE;
      end
      ARB_TX_FORCE: begin
        // A blocked port freezes the force; otherwise leave after one cycle
        // whether or not TX still wants the slot.
        if (!mem_block) begin
          w_tx_gnt      = tx_req;
          w_state_next  = ARB_HDMI;
          w_starve_next = '0;
        end
      end
      default: begin
        w_state_next  = ARB_HDMI;
        w_starve_next = '0;
      end
    endcase
  end

  assign hdmi_gnt = w_hdmi_gnt;
  assign tx_gnt   = w_tx_gnt;
  assign mem_re   = w_hdmi_gnt | w_tx_gnt;
  assign mem_addr = w_tx_gnt ? tx_addr : hdmi_addr;

  assign w_tag.valid = w_hdmi_gnt | w_tx_gnt;
  assign w_tag.is_tx = w_tx_gnt;

  slant_arb_retpipe #(
    .RD_LAT (RD_LAT)
  ) u_retpipe (
    .i_clk   (Cclk),
    .i_rst_n (rstn),
    .i_tag   (w_tag),
    .o_tag   (w_tail)
  );

  assign hdmi_rvalid = w_tail.valid & ~w_tail.is_tx;
  assign tx_rvalid   = w_tail.valid &  w_tail.is_tx;

  // Pass the bus word through on the owner's return cycle; the hold
  // registers keep each side's last word between returns.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_hdmi_hold <= '0;
      r_tx_hold   <= '0;
    end else begin
      if (hdmi_rvalid) r_hdmi_hold <= mem_rdata;
      if (tx_rvalid)   r_tx_hold   <= mem_rdata;
    end
  end

  assign hdmi_rdata = hdmi_rvalid ? mem_rdata : r_hdmi_hold;
  assign tx_rdata   = tx_rvalid   ? mem_rdata : r_tx_hold;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_hdmi;
  logic [STAT_W-1:0] r_stat_tx;
  logic [STAT_W-1:0] r_stat_force;

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_stat_hdmi  <= '0;
      r_stat_tx    <= '0;
      r_stat_force <= '0;
    end else if (stat_clr) begin
      r_stat_hdmi  <= '0;
      r_stat_tx    <= '0;
      r_stat_force <= '0;
    end else begin
      r_stat_hdmi  <= sat_inc(r_stat_hdmi, w_hdmi_gnt);
      r_stat_tx    <= sat_inc(r_stat_tx, w_tx_gnt);
      r_stat_force <= sat_inc(r_stat_force, w_tx_gnt && (r_state == ARB_TX_FORCE));
    end
  end

  assign stat_hdmi  = r_stat_hdmi;
  assign stat_tx    = r_stat_tx;
  assign stat_force = r_stat_force;
`endif

endmodule

// File: tb/tb_slant_rd_arbiter.sv
// tb_slant_rd_arbiter
//   Directed bench for slant_rd_arbiter. Two instances share the request
//   inputs: dut1 (RD_LAT=1) and dut3 (RD_LAT=3), each with its own memory
//   model returning fmem(addr) RD_LAT cycles after the read.
//   Build with ARB_STATS_EN defined to also exercise the statistics.
module tb_slant_rd_arbiter;
  import slant_arb_pkg::*;

  logic        Cclk = 1'b0;
  logic        rstn;
  logic        mem_block;
  logic        hdmi_req;
  logic [16:0] hdmi_addr;
  logic        tx_req;
  logic [16:0] tx_addr;

  logic        hdmi_gnt_1, hdmi_rvalid_1, tx_gnt_1, tx_rvalid_1, mem_re_1;
  logic [19:0] hdmi_rdata_1, tx_rdata_1, mem_rdata_1;
  logic [16:0] mem_addr_1;
  logic        hdmi_gnt_3, hdmi_rvalid_3, tx_gnt_3, tx_rvalid_3, mem_re_3;
  logic [19:0] hdmi_rdata_3, tx_rdata_3, mem_rdata_3;
  logic [16:0] mem_addr_3;
  logic [19:0] m3a, m3b;
`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_hdmi_1, stat_tx_1, stat_force_1;
  logic [15:0] stat_hdmi_3, stat_tx_3, stat_force_3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 Cclk = ~Cclk;

  function automatic logic [19:0] fmem(input logic [16:0] a);
    return {a, 3'b101} ^ 20'h5A5A5;
  endfunction

  always @(posedge Cclk) begin
    mem_rdata_1 <= fmem(mem_addr_1);
    m3a         <= fmem(mem_addr_3);
    m3b         <= m3a;
    mem_rdata_3 <= m3b;
  end

  slant_rd_arbiter #(.ADDR_W(17), .DATA_W(20), .RD_LAT(1), .STARVE_MAX(8)) dut1 (
    .Cclk(Cclk), .rstn(rstn), .mem_block(mem_block),
    .hdmi_req(hdmi_req), .hdmi_addr(hdmi_addr), .hdmi_gnt(hdmi_gnt_1),
    .hdmi_rvalid(hdmi_rvalid_1), .hdmi_rdata(hdmi_rdata_1),
    .tx_req(tx_req), .tx_addr(tx_addr), .tx_gnt(tx_gnt_1),
    .tx_rvalid(tx_rvalid_1), .tx_rdata(tx_rdata_1),
    .mem_re(mem_re_1), .mem_addr(mem_addr_1), .mem_rdata(mem_rdata_1)
`ifdef ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_hdmi(stat_hdmi_1), .stat_tx(stat_tx_1), .stat_force(stat_force_1)
`endif
  );

  slant_rd_arbiter #(.ADDR_W(17), .DATA_W(20), .RD_LAT(3), .STARVE_MAX(8)) dut3 (
    .Cclk(Cclk), .rstn(rstn), .mem_block(mem_block),
    .hdmi_req(hdmi_req), .hdmi_addr(hdmi_addr), .hdmi_gnt(hdmi_gnt_3),
    .hdmi_rvalid(hdmi_rvalid_3), .hdmi_rdata(hdmi_rdata_3),
    .tx_req(tx_req), .tx_addr(tx_addr), .tx_gnt(tx_gnt_3),
    .tx_rvalid(tx_rvalid_3), .tx_rdata(tx_rdata_3),
    .mem_re(mem_re_3), .mem_addr(mem_addr_3), .mem_rdata(mem_rdata_3)
`ifdef ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_hdmi(stat_hdmi_3), .stat_tx(stat_tx_3), .stat_force(stat_force_3)
`endif
  );

  task automatic test_reset;
    @(posedge Cclk); #1;
    @(negedge Cclk);
    n_cmp++;
    if ({hdmi_gnt_1, tx_gnt_1, mem_re_1, hdmi_rvalid_1, tx_rvalid_1} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got=%b want=00000",
        {hdmi_gnt_1, tx_gnt_1, mem_re_1, hdmi_rvalid_1, tx_rvalid_1});
    end
    n_cmp++;
    if ({hdmi_rdata_1, tx_rdata_1, mem_addr_1} !== 57'd0) begin
      n_err++; $display("FAIL reset_data got=%h/%h/%h want=0", hdmi_rdata_1, tx_rdata_1, mem_addr_1);
    end
    n_cmp++;
    if (dut1.r_state !== ARB_HDMI || dut1.r_starve_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_state got=%0d/%0d want=0/0", dut1.r_state, dut1.r_starve_cnt);
    end
    $display("reset check done");
    @(posedge Cclk); #1; rstn = 1'b1;
  endtask

  task automatic test_hdmi_stream;
    for (int i = 0; i <= 10; i++) begin
      @(posedge Cclk); #1;
      tx_req = 1'b0;
      hdmi_req  = (i < 10);
      hdmi_addr = (i < 10) ? 17'(i) : 17'd0;
      @(negedge Cclk);
      n_cmp++;
      if (hdmi_gnt_1 !== (i < 10) || tx_gnt_1 !== 1'b0 || mem_re_1 !== (i < 10)) begin
        n_err++; $display("FAIL stream_gnt i=%0d got=%b%b%b want=%b0%b", i,
          hdmi_gnt_1, tx_gnt_1, mem_re_1, (i < 10), (i < 10));
      end
      if (i < 10) begin
        n_cmp++;
        if (mem_addr_1 !== 17'(i)) begin
          n_err++; $display("FAIL stream_addr i=%0d got=%h want=%h", i, mem_addr_1, 17'(i));
        end
      end
      n_cmp++;
      if (hdmi_rvalid_1 !== (i >= 1) || tx_rvalid_1 !== 1'b0) begin
        n_err++; $display("FAIL stream_rvalid i=%0d got=%b%b want=%b0", i, hdmi_rvalid_1, tx_rvalid_1, (i >= 1));
      end
      if (i >= 1) begin
        n_cmp++;
        if (hdmi_rdata_1 !== fmem(17'(i - 1))) begin
          n_err++; $display("FAIL stream_data i=%0d got=%h want=%h", i, hdmi_rdata_1, fmem(17'(i - 1)));
        end
        $display("hdmi read addr=%0d data=%h", i - 1, hdmi_rdata_1);
      end
    end
  endtask

  task automatic test_starve;
    logic [16:0] ha, ta;
    logic        pv, pt, exp_tx;
    logic [19:0] pd, last_h, last_t;
    ha = 17'h01000; ta = 17'h02000;
    pv = 1'b0; pt = 1'b0; pd = '0;
    last_h = fmem(17'd9); last_t = 20'd0;
    for (int c = 0; c < 27; c++) begin
      @(posedge Cclk); #1;
      hdmi_req = 1'b1; tx_req = 1'b1; hdmi_addr = ha; tx_addr = ta;
      @(negedge Cclk);
      exp_tx = ((c % 9) == 8);
      n_cmp++;
      if (tx_gnt_1 !== exp_tx || hdmi_gnt_1 !== !exp_tx) begin
        n_err++; $display("FAIL starve_gnt c=%0d got h=%b t=%b want t=%b", c, hdmi_gnt_1, tx_gnt_1, exp_tx);
      end
      n_cmp++;
      if (mem_addr_1 !== (exp_tx ? ta : ha)) begin
        n_err++; $display("FAIL starve_addr c=%0d got=%h want=%h", c, mem_addr_1, exp_tx ? ta : ha);
      end
      n_cmp++;
      if (hdmi_rvalid_1 !== (pv && !pt) || tx_rvalid_1 !== (pv && pt)) begin
        n_err++; $display("FAIL starve_rvalid c=%0d got h=%b t=%b want h=%b t=%b", c,
          hdmi_rvalid_1, tx_rvalid_1, pv && !pt, pv && pt);
      end
      if (pv && pt)  last_t = pd;
      if (pv && !pt) last_h = pd;
      n_cmp++;
      if (hdmi_rdata_1 !== last_h || tx_rdata_1 !== last_t) begin
        n_err++; $display("FAIL starve_rdata c=%0d got h=%h t=%h want h=%h t=%h", c,
          hdmi_rdata_1, tx_rdata_1, last_h, last_t);
      end
      $display("starve cycle %0d winner=%s", c, exp_tx ? "tx" : "hdmi");
      pv = 1'b1; pt = exp_tx; pd = fmem(exp_tx ? ta : ha);
      if (exp_tx) ta = ta + 17'd1;
      else        ha = ha + 17'd1;
    end
  endtask

  task automatic test_block;
    hdmi_addr = 17'h00555; tx_addr = 17'h00666;
    for (int c = 0; c < 3; c++) begin
      @(posedge Cclk); #1; mem_block = 1'b0; hdmi_req = 1'b1; tx_req = 1'b1;
      @(negedge Cclk);
      n_cmp++;
      if (hdmi_gnt_1 !== 1'b1 || tx_gnt_1 !== 1'b0) begin
        n_err++; $display("FAIL block_pre c=%0d got h=%b t=%b want h=1 t=0", c, hdmi_gnt_1, tx_gnt_1);
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge Cclk); #1; mem_block = 1'b1;
      @(negedge Cclk);
      n_cmp++;
      if ({hdmi_gnt_1, tx_gnt_1, mem_re_1} !== 3'b000 || dut1.r_starve_cnt !== 8'd3) begin
        n_err++; $display("FAIL block_hold c=%0d got gnt/re=%b cnt=%0d want 000 cnt=3", c,
          {hdmi_gnt_1, tx_gnt_1, mem_re_1}, dut1.r_starve_cnt);
      end
      $display("blocked cycle %0d", c);
    end
    @(posedge Cclk); #1; mem_block = 1'b0;
    @(negedge Cclk);
    n_cmp++;
    if (hdmi_gnt_1 !== 1'b1 || mem_re_1 !== 1'b1 || mem_addr_1 !== 17'h00555) begin
      n_err++; $display("FAIL block_resume got h=%b re=%b addr=%h want 1 1 00555", hdmi_gnt_1, mem_re_1, mem_addr_1);
    end
  endtask

  task automatic test_force_drop;
    @(posedge Cclk); #1; rstn = 1'b0; hdmi_req = 1'b0; tx_req = 1'b0; mem_block = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Cclk); #1; rstn = 1'b1; hdmi_req = 1'b1; tx_req = 1'b1;
      @(negedge Cclk);
      n_cmp++;
      if (hdmi_gnt_1 !== 1'b1 || tx_gnt_1 !== 1'b0) begin
        n_err++; $display("FAIL force_pre c=%0d got h=%b t=%b want h=1 t=0", c, hdmi_gnt_1, tx_gnt_1);
      end
    end
    @(posedge Cclk); #1; tx_req = 1'b0;
    @(negedge Cclk);
    n_cmp++;
    if (dut1.r_state !== ARB_TX_FORCE || dut1.r_starve_cnt !== 8'd8 ||
        {hdmi_gnt_1, tx_gnt_1, mem_re_1} !== 3'b000) begin
      n_err++; $display("FAIL force_drop got st=%0d cnt=%0d gnt/re=%b want st=1 cnt=8 000",
        dut1.r_state, dut1.r_starve_cnt, {hdmi_gnt_1, tx_gnt_1, mem_re_1});
    end
    @(posedge Cclk); #1;
    @(negedge Cclk);
    n_cmp++;
    if (hdmi_gnt_1 !== 1'b1 || dut1.r_state !== ARB_HDMI || dut1.r_starve_cnt !== 8'd0) begin
      n_err++; $display("FAIL force_after got h=%b st=%0d cnt=%0d want 1 0 0",
        hdmi_gnt_1, dut1.r_state, dut1.r_starve_cnt);
    end
    $display("force slot dropped, hdmi resumed");
    @(posedge Cclk); #1; hdmi_req = 1'b0;
  endtask

  task automatic test_reset_inflight;
    logic [19:0] exp_d [6];
    logic        exp_t [6];
    @(posedge Cclk); #1; rstn = 1'b0; hdmi_req = 1'b0; tx_req = 1'b0; mem_block = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge Cclk); #1; rstn = 1'b1;
      hdmi_req = ((c % 2) == 0); tx_req = ((c % 2) == 1);
      hdmi_addr = 17'h00300 + 17'(c); tx_addr = 17'h00400 + 17'(c);
      exp_t[c] = ((c % 2) == 1);
      exp_d[c] = fmem(exp_t[c] ? tx_addr : hdmi_addr);
      @(negedge Cclk);
      n_cmp++;
      if (hdmi_gnt_3 !== !exp_t[c] || tx_gnt_3 !== exp_t[c]) begin
        n_err++; $display("FAIL lat3_gnt c=%0d got h=%b t=%b want t=%b", c, hdmi_gnt_3, tx_gnt_3, exp_t[c]);
      end
      if (c >= 3) begin
        n_cmp++;
        if (hdmi_rvalid_3 !== !exp_t[c-3] || tx_rvalid_3 !== exp_t[c-3] ||
            (exp_t[c-3] ? tx_rdata_3 : hdmi_rdata_3) !== exp_d[c-3]) begin
          n_err++; $display("FAIL lat3_ret c=%0d got h=%b t=%b d=%h/%h want t=%b d=%h", c,
            hdmi_rvalid_3, tx_rvalid_3, hdmi_rdata_3, tx_rdata_3, exp_t[c-3], exp_d[c-3]);
        end
        $display("lat3 return c=%0d owner=%s", c, exp_t[c-3] ? "tx" : "hdmi");
      end else begin
        n_cmp++;
        if (hdmi_rvalid_3 !== 1'b0 || tx_rvalid_3 !== 1'b0) begin
          n_err++; $display("FAIL lat3_early c=%0d got h=%b t=%b want 0 0", c, hdmi_rvalid_3, tx_rvalid_3);
        end
      end
    end
    @(posedge Cclk); #1; rstn = 1'b0; hdmi_req = 1'b0; tx_req = 1'b0;
    @(negedge Cclk);
    n_cmp++;
    if ({hdmi_gnt_3, tx_gnt_3, mem_re_3, hdmi_rvalid_3, tx_rvalid_3} !== 5'b0 ||
        hdmi_rdata_3 !== 20'd0 || tx_rdata_3 !== 20'd0) begin
      n_err++; $display("FAIL lat3_inreset got flags=%b d=%h/%h want 0",
        {hdmi_gnt_3, tx_gnt_3, mem_re_3, hdmi_rvalid_3, tx_rvalid_3}, hdmi_rdata_3, tx_rdata_3);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge Cclk); #1; rstn = 1'b1;
      @(negedge Cclk);
      n_cmp++;
      if (hdmi_rvalid_3 !== 1'b0 || tx_rvalid_3 !== 1'b0 || hdmi_rdata_3 !== 20'd0 || tx_rdata_3 !== 20'd0) begin
        n_err++; $display("FAIL lat3_post c=%0d got v=%b%b d=%h/%h want 0", c,
          hdmi_rvalid_3, tx_rvalid_3, hdmi_rdata_3, tx_rdata_3);
      end
    end
    $display("in-flight reads discarded by reset");
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats;
    @(posedge Cclk); #1; stat_clr = 1'b1; hdmi_req = 1'b0; tx_req = 1'b0;
    @(posedge Cclk); #1; stat_clr = 1'b0; hdmi_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge Cclk); #1;
    end
    hdmi_req = 1'b0;
    @(negedge Cclk);
    n_cmp++;
    if (stat_hdmi_1 !== 16'd10) begin
      n_err++; $display("FAIL stat_count got=%0d want=10", stat_hdmi_1);
    end
    hdmi_req = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      @(posedge Cclk); #1;
    end
    @(negedge Cclk);
    n_cmp++;
    if (stat_hdmi_1 !== 16'hFFFF || stat_tx_1 !== 16'd0 || stat_force_1 !== 16'd0) begin
      n_err++; $display("FAIL stat_sat got=%h/%h/%h want=ffff/0/0", stat_hdmi_1, stat_tx_1, stat_force_1);
    end
    @(posedge Cclk); #1; stat_clr = 1'b1;
    @(posedge Cclk); #1; stat_clr = 1'b0;
    @(negedge Cclk);
    n_cmp++;
    if (stat_hdmi_1 !== 16'd0 || stat_tx_1 !== 16'd0 || stat_force_1 !== 16'd0) begin
      n_err++; $display("FAIL stat_clr got=%h/%h/%h want=0/0/0", stat_hdmi_1, stat_tx_1, stat_force_1);
    end
    $display("stats saturated and cleared");
    hdmi_req = 1'b0;
  endtask
`endif

  initial begin
    rstn = 1'b0; mem_block = 1'b0;
    hdmi_req = 1'b0; hdmi_addr = '0; tx_req = 1'b0; tx_addr = '0;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_hdmi_stream();
    test_starve();
    test_block();
    test_force_drop();
    test_reset_inflight();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
